// File: rtl/alu_op_issuer.sv
// Command-driven initiator for an external combinational 32-bit ALU.
// Owns a register file with a load port; one command in flight, 4-cycle cadence.
module alu_op_issuer #(
  parameter int NREG = 8,
  parameter int AW   = 3,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [4:0]    cmd_op,
  input  logic [AW-1:0] cmd_rs,
  input  logic [AW-1:0] cmd_rt,
  input  logic [AW-1:0] cmd_rd,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [4:0]    alu_op,
  input  logic [DW-1:0] alu_out,
  output logic          done,
  output logic [AW-1:0] done_rd,
  output logic [DW-1:0] done_data,
  output logic          busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_EX   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] regs_d [NREG];
  logic [4:0]    op_q, op_d;
  logic [AW-1:0] rs_q, rs_d;
  logic [AW-1:0] rt_q, rt_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [DW-1:0] alu_a_q, alu_a_d;
  logic [DW-1:0] alu_b_q, alu_b_d;
  logic [4:0]    alu_op_q, alu_op_d;
  logic [AW-1:0] done_rd_q, done_rd_d;
  logic [DW-1:0] done_data_q, done_data_d;

  always_comb begin
    state_d     = state_q;
    regs_d      = regs_q;
    op_d        = op_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    rd_d        = rd_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    done_rd_d   = done_rd_q;
    done_data_d = done_data_q;
    case (state_q)
      S_IDLE: begin
        // Load lands on the accept edge, so the following RD sees it.
        if (ld_valid && (ld_addr != '0)) regs_d[ld_addr] = ld_data;
        if (cmd_valid) begin
          op_d    = cmd_op;
          rs_d    = cmd_rs;
          rt_d    = cmd_rt;
          rd_d    = cmd_rd;
          state_d = S_RD;
        end
      end
      S_RD: begin
        alu_a_d  = (rs_q == '0) ? '0 : regs_q[rs_q];
        alu_b_d  = (rt_q == '0) ? '0 : regs_q[rt_q];
        alu_op_d = op_q;
        state_d  = S_EX;
      end
      S_EX: begin
        if (rd_q != '0) regs_d[rd_q] = alu_out;
        done_data_d = alu_out;
        done_rd_d   = rd_q;
        alu_op_d    = '0;
        state_d     = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
      op_q        <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      done_rd_q   <= '0;
      done_data_q <= '0;
    end else begin
      state_q     <= state_d;
      regs_q      <= regs_d;
      op_q        <= op_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rd_q        <= rd_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      done_rd_q   <= done_rd_d;
      done_data_q <= done_data_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = ~cmd_ready;
  assign done      = (state_q == S_DONE);
  assign done_rd   = done_rd_q;
  assign done_data = done_data_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;

endmodule

// File: tb/tb_alu_op_issuer.sv
// Scoreboard bench for alu_op_issuer: expected results queued at issue,
// compared when done pulses; includes a behavioural ALU.
module tb_alu_op_issuer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [4:0]  cmd_op;
  logic [2:0]  cmd_rs, cmd_rt, cmd_rd;
  logic        ld_valid;
  logic [2:0]  ld_addr;
  logic [31:0] ld_data;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [4:0]  alu_op;
  logic        done;
  logic [2:0]  done_rd;
  logic [31:0] done_data;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int          acc_q [$];
  logic [2:0]  sb_rd [$];
  logic [31:0] sb_data [$];
  logic        done_prev = 1'b0;

  alu_op_issuer #(.NREG(8), .AW(3), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
    .done(done), .done_rd(done_rd), .done_data(done_data), .busy(busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (alu_op)
      5'd1:    alu_out = alu_a + alu_b;
      5'd2:    alu_out = alu_a - alu_b;
      5'd3:    alu_out = alu_a & alu_b;
      5'd4:    alu_out = alu_a | alu_b;
      5'd5:    alu_out = alu_a ^ alu_b;
      5'd6:    alu_out = ~(alu_a | alu_b);
      default: alu_out = 32'd0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (done_prev) chk("done_width", 32'd2, 32'd1);
      if (sb_rd.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        chk("done_rd", {29'd0, done_rd}, {29'd0, sb_rd.pop_front()});
        chk("done_data", done_data, sb_data.pop_front());
        if (acc_q.size() != 0) chk("latency", cyc - acc_q.pop_front(), 32'd3);
      end
    end
    done_prev <= rst_n && done;
  end

  task automatic wait_drain();
    int n = 0;
    while (sb_rd.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) chk("drain_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  // ld_mode: 0 none, 1 load on the accept edge, 2 load held while busy
  task automatic issue(input logic [4:0] op, input logic [2:0] rs, input logic [2:0] rt,
                       input logic [2:0] rd, input logic [31:0] exp, input int ld_mode,
                       input logic [2:0] la, input logic [31:0] ldd);
    wait_ready();
    cmd_op = op; cmd_rs = rs; cmd_rt = rt; cmd_rd = rd; cmd_valid = 1'b1;
    if (ld_mode == 1) begin ld_valid = 1'b1; ld_addr = la; ld_data = ldd; end
    acc_q.push_back(cyc);
    sb_rd.push_back(rd);
    sb_data.push_back(exp);
    @(negedge clk);
    cmd_valid = 1'b0;
    ld_valid  = 1'b0;
    if (ld_mode == 2) begin ld_valid = 1'b1; ld_addr = la; ld_data = ldd; end
    @(negedge clk);
    chk("alu_op_issue", {27'd0, alu_op}, {27'd0, op});
    wait_drain();
    ld_valid = 1'b0;
  endtask

  task automatic load(input logic [2:0] a, input logic [31:0] d);
    wait_ready();
    ld_valid = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  task automatic read_reg(input logic [2:0] r, input logic [31:0] exp);
    issue(5'd1, r, 3'd0, 3'd0, exp, 0, 3'd0, 32'd0);
  endtask

  initial begin
    logic [31:0] sweep [8];
    logic [4:0]  sweep_op [8];
    int t [3];
    int n;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_rs = '0; cmd_rt = '0; cmd_rd = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_op", {27'd0, alu_op}, 32'd0);
    chk("rst_done_rd", {29'd0, done_rd}, 32'd0);
    chk("rst_done_data", done_data, 32'd0);
    rst_n = 1'b1;
    for (int r = 1; r < 8; r++) read_reg(3'(r), 32'd0);

    // Load + ADD with wrap-around
    load(3'd1, 32'h0000_0005);
    load(3'd2, 32'hFFFF_FFFD);
    issue(5'd1, 3'd1, 3'd2, 3'd3, 32'h0000_0002, 0, 3'd0, 32'd0);
    chk("add_alu_a", alu_a, 32'h0000_0005);
    chk("add_alu_b", alu_b, 32'hFFFF_FFFD);
    chk("add_alu_op_cleared", {27'd0, alu_op}, 32'd0);
    chk("done_low_after", {31'd0, done}, 32'd0);
    chk("done_data_held", done_data, 32'h0000_0002);

    // Opcode sweep
    load(3'd1, 32'hF0F0_F0F0);
    load(3'd2, 32'h0FF0_0FF0);
    sweep = '{32'h0, 32'h00E1_00E0, 32'hE100_E100, 32'h00F0_00F0,
              32'hFFF0_FFF0, 32'hFF00_FF00, 32'h000F_000F, 32'h0};
    sweep_op = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd9};
    for (int i = 0; i < 8; i++) begin
      issue(sweep_op[i], 3'd1, 3'd2, 3'd3, sweep[i], 0, 3'd0, 32'd0);
      read_reg(3'd3, sweep[i]);
    end

    // Back-to-back: cmd_valid held high, accepts must be 4 cycles apart
    for (int i = 0; i < 3; i++) begin
      sb_rd.push_back(3'd6);
      sb_data.push_back(32'h00E1_00E0);
    end
    wait_ready();
    cmd_op = 5'd1; cmd_rs = 3'd1; cmd_rt = 3'd2; cmd_rd = 3'd6; cmd_valid = 1'b1;
    n = 0;
    for (int i = 0; i < 40 && n < 3; i++) begin
      if (cmd_ready) begin
        t[n] = cyc;
        acc_q.push_back(cyc);
        n++;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("b2b_accepts", 32'(n), 32'd3);
    chk("b2b_gap0", 32'(t[1] - t[0]), 32'd4);
    chk("b2b_gap1", 32'(t[2] - t[1]), 32'd4);
    wait_drain();

    // Load while busy is dropped
    issue(5'd4, 3'd1, 3'd0, 3'd7, 32'hF0F0_F0F0, 2, 3'd2, 32'hDEAD_BEEF);
    read_reg(3'd2, 32'h0FF0_0FF0);

    // Same-edge load and command
    issue(5'd1, 3'd1, 3'd1, 3'd4, 32'd14, 1, 3'd1, 32'd7);
    read_reg(3'd4, 32'd14);

    // R0 rules
    load(3'd0, 32'h0000_1234);
    issue(5'd1, 3'd0, 3'd0, 3'd0, 32'd0, 0, 3'd0, 32'd0);
    issue(5'd4, 3'd0, 3'd0, 3'd1, 32'd0, 0, 3'd0, 32'd0);
    read_reg(3'd1, 32'd0);

    // Reset in EX: abandoned, no done
    load(3'd1, 32'd3);
    wait_ready();
    cmd_op = 5'd1; cmd_rs = 3'd1; cmd_rt = 3'd1; cmd_rd = 3'd5; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_no_done", {31'd0, done}, 32'd0);
    read_reg(3'd5, 32'd0);
    read_reg(3'd1, 32'd0);

    wait_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_op_issuer.md
# alu_op_issuer

Command-driven initiator for the 32-bit combinational ALU (opcodes NOP/ADD/SUB/AND/OR/XOR/NOR, 5-bit code).
- Owns a small register file and a load port.
- Accepts one register-to-register command at a time over a valid/ready handshake, then drives the ALU operand and opcode lines from registers.
- Samples the ALU result and writes it back.
- Sits between the test/control front end and the ALU; the ALU itself stays external and purely combinational.

## Interface
Parameters:
- NREG, 8: register count; register 0 reads as zero.
- AW, 3: register address width, log2(NREG).
- DW, 32: data width; must match the ALU.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE; a command is accepted on an edge where cmd_valid & cmd_ready.
- cmd_op  in  5  ALU opcode: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 NOR; 7–31 passed through unchanged.
- cmd_rs, cmd_rt, cmd_rd  in  AW each  source A, source B and destination register.
- ld_valid  in  1  load-port write request.
- ld_addr  in  AW  load-port destination register.
- ld_data  in  DW  load-port data.
- alu_a, alu_b  out  DW each  registered operands to the ALU.
- alu_op  out  5  registered opcode to the ALU.
- alu_out  in  DW  combinational ALU result.
- done  out  1  one-cycle pulse when a result has been written back.
- done_rd  out  AW  destination register of the completed command; valid with done.
- done_data  out  DW  written-back value; valid with done.
- busy  out  1  ~cmd_ready.

## Operation
States:
- IDLE: cmd_ready=1. On accept, latch op/rs/rt/rd and go to RD.
- RD: alu_a <= R[rs], alu_b <= R[rt], alu_op <= op; go to EX.
- EX: ALU settles. At the edge leaving EX: R[rd] <= alu_out (dropped if rd=0), result <= alu_out, alu_op <= 0; go to DONE.
- DONE: done=1, done_rd/done_data presented; go to IDLE.

Register file:
- Reads of R[0] return 0; writes to R[0] are silently discarded (both cmd and load paths).
- A load is accepted only on edges where the state is IDLE. ld_valid in any other state is dropped, with no buffering.
- A load and a command accepted on the same edge: the load is written at that edge. RD reads one edge later, so it sees the loaded value.

Result arithmetic:
- Modulo 2^DW; no overflow or carry flags. SUB is alu_a − alu_b, two's complement.
- Opcodes 7–31 are forwarded unchanged; the ALU returns 0 for them, and that 0 is written back.

## Timing
- Accept at edge E0. Operands/opcode appear on ALU ports after E1. Write-back and result capture at E2. done high for the cycle E2–E3. cmd_ready returns high after E3.
- Next accept is E4 at the earliest: throughput 1 command per 4 cycles. Latency accept→done is 3 cycles.
- cmd_ready is a registered state decode; it does not depend combinationally on cmd_valid.
- done, done_rd and done_data are held only during DONE. Outside DONE: done=0, and done_rd/done_data keep their last values.
- Reset (rst_n=0 at an edge), taken in any state including mid-command:
  - state=IDLE; all registers 0; alu_a=alu_b=0; alu_op=0; done=0; done_rd=0; done_data=0.
  - The in-flight command is abandoned with no write-back.
- Outputs immediately after reset: cmd_ready=1, busy=0.

## Test plan
- Reset values: hold rst_n=0 for 2 cycles -> all outputs 0 except cmd_ready=1; dbg-read via commands shows R1..R7 = 0.
- Load + ADD: load R1=0x0000_0005, R2=0xFFFF_FFFD; issue ADD rs=1 rt=2 rd=3 -> alu_a=5, alu_b=0xFFFFFFFD, alu_op=1 one cycle after accept; done 3 cycles after accept with done_rd=3, done_data=0x0000_0002.
- All opcodes: R1=0xF0F0_F0F0, R2=0x0FF0_0FF0; sweep ops 0–6 into R3 -> done_data 0, 0x00E1_00E0, 0xE100_E100, 0x00F0_00F0, 0xFFF0_FFF0, 0xFF00_FF00, 0x000F_000F; op 9 -> 0.
- Handshake/collision: hold cmd_valid continuously -> accepts spaced exactly 4 cycles apart; ld_valid asserted while busy -> target register unchanged. Same-edge load R1=7 + ADD R1+R1→R4 -> done_data=14.
- R0 rules: ld R0=0x1234 then ADD rs=0 rt=0 rd=0 -> done_data=0, R0 still reads 0.
- Reset mid-op: assert rst_n=0 in the EX cycle of ADD→R5 -> no done pulse, R5=0, state IDLE on the next cycle.
